// File: rtl/wb_iomux.sv
// Pipelined Wishbone fan-out to four I/O slaves in a single address region.
// Responses stay ordered by pinning one owning slave until its requests drain.
module wb_iomux #(
    parameter int unsigned         SEL_LSB   = 4,
    parameter logic [27-SEL_LSB:0] IO_REGION = '1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wb_cyc,
    input  logic         i_wb_stb,
    input  logic         i_wb_we,
    input  logic [29:0]  i_wb_addr,
    input  logic [31:0]  i_wb_data,
    input  logic [3:0]   i_wb_sel,
    output logic         o_wb_ack,
    output logic         o_wb_stall,
    output logic         o_wb_err,
    output logic [31:0]  o_wb_data,
    output logic [3:0]   o_s_cyc,
    output logic [3:0]   o_s_stb,
    output logic         o_s_we,
    output logic [29:0]  o_s_addr,
    output logic [31:0]  o_s_data,
    output logic [3:0]   o_s_sel,
    input  logic [3:0]   i_s_ack,
    input  logic [3:0]   i_s_stall,
    input  logic [127:0] i_s_data
);

    logic [1:0] owner;
    logic       owner_valid;
    logic [3:0] outstanding;
    logic       err_pend;

    logic [1:0] target;
    logic       mapped;
    logic       busy;
    logic       hold;
    logic       accept;
    logic       accept_map;
    logic       accept_unmap;

    assign target = i_wb_addr[SEL_LSB+1:SEL_LSB];
    assign mapped = (i_wb_addr[29:SEL_LSB+2] == IO_REGION);
    assign busy   = (outstanding != 4'd0);

    // A request waits while another slave still owes responses, so acks
    // can never arrive out of order.
    assign hold = i_wb_stb && ((owner_valid && busy && (target != owner))
                               || (outstanding == 4'd15)
                               || (!mapped && busy)
                               || err_pend);

    assign o_wb_stall = hold || (i_wb_stb && mapped && i_s_stall[target]) || i_reset;

    assign accept       = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign accept_map   = accept && mapped;
    assign accept_unmap = accept && !mapped;

    always_comb begin
        o_s_stb = '0;
        o_s_cyc = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o_s_stb[k] = i_wb_cyc && i_wb_stb && mapped && !hold && !i_reset
                         && (target == k[1:0]);
            o_s_cyc[k] = i_wb_cyc && !i_reset
                         && ((owner_valid && (owner == k[1:0])) || o_s_stb[k]);
        end
    end

    assign o_wb_ack  = i_wb_cyc && !i_reset && owner_valid && busy && i_s_ack[owner];
    assign o_wb_data = o_wb_ack ? i_s_data[{owner, 5'd0} +: 32] : '0;
    assign o_wb_err  = err_pend && i_wb_cyc && !i_reset;

    assign o_s_we   = i_wb_we;
    assign o_s_addr = i_wb_addr;
    assign o_s_data = i_wb_data;
    assign o_s_sel  = i_wb_sel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner       <= '0;
            owner_valid <= 1'b0;
            outstanding <= '0;
            err_pend    <= 1'b0;
        end else if (!i_wb_cyc) begin
            owner_valid <= 1'b0;
            outstanding <= '0;
            err_pend    <= 1'b0;
        end else begin
            if (accept_map) begin
                owner       <= target;
                owner_valid <= 1'b1;
            end
            case ({accept_map, o_wb_ack})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
            err_pend <= accept_unmap;
        end
    end

endmodule
